// File: rtl/l2_output_encoder_pkg.sv
// rtl/l2_output_encoder_pkg.sv - Spandex L2 message types shared by the output encoder and its FIFOs.
package l2_output_encoder_pkg;

    typedef logic [2:0]   coh_msg_t;
    typedef logic [1:0]   hprot_t;
    typedef logic [27:0]  line_addr_t;
    typedef logic [127:0] line_t;
    typedef logic [3:0]   word_mask_t;
    typedef logic [3:0]   cache_id_t;

    localparam coh_msg_t REQ_S  = 3'd1;
    localparam coh_msg_t REQ_O  = 3'd2;
    localparam coh_msg_t REQ_WB = 3'd3;
    localparam coh_msg_t RSP_V  = 3'd4;

    typedef struct packed {
        coh_msg_t   coh_msg;
        hprot_t     hprot;
        line_addr_t addr;
        line_t      line;
        word_mask_t word_mask;
    } l2_req_out_t;

    typedef struct packed {
        coh_msg_t   coh_msg;
        cache_id_t  req_id;
        logic       to_req;
        line_addr_t addr;
        line_t      line;
        word_mask_t word_mask;
    } l2_rsp_out_t;

endpackage

// File: rtl/l2_out_fifo.sv
// rtl/l2_out_fifo.sv - Generic per-channel staging FIFO; optional same-cycle bypass under L2_OUT_BYPASS_EN.
module l2_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop;
    logic             push;
    logic             bypass_take;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign pop   = !empty && ready;

`ifdef L2_OUT_BYPASS_EN
    // An empty FIFO presents the incoming entry directly; if taken, it never lands in mem.
    assign bypass_take = empty && set && ready;
    assign valid       = !empty || set;
    assign rdata       = (empty && set) ? wdata : mem[rd_ptr];
`else
    assign bypass_take = 1'b0;
    assign valid       = !empty;
    assign rdata       = mem[rd_ptr];
`endif

    // A write into a full FIFO only lands when the head leaves on the same edge.
    assign push = set && (!full || pop) && !bypass_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            assert (!(set && full && !pop))
                else $warning("l2_out_fifo: set while stalled, entry dropped");
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/l2_output_encoder.sv
// rtl/l2_output_encoder.sv - Spandex L2 output staging: four independent buffered channels (bypass: L2_OUT_BYPASS_EN).
module l2_output_encoder
    import l2_output_encoder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        set_req_out,
    input  coh_msg_t    req_out_coh_msg,
    input  hprot_t      req_out_hprot,
    input  line_addr_t  req_out_addr,
    input  line_t       req_out_line,
    input  word_mask_t  req_out_word_mask,

    input  logic        set_rsp_out,
    input  coh_msg_t    rsp_out_coh_msg,
    input  cache_id_t   rsp_out_req_id,
    input  logic        rsp_out_to_req,
    input  line_addr_t  rsp_out_addr,
    input  line_t       rsp_out_line,
    input  word_mask_t  rsp_out_word_mask,

    input  logic        set_rd_rsp,
    input  line_t       rd_rsp_line,

    input  logic        set_inval,
    input  line_addr_t  inval_addr,

    input  logic        l2_req_out_ready_int,
    input  logic        l2_rsp_out_ready_int,
    input  logic        l2_rd_rsp_ready_int,
    input  logic        l2_inval_ready_int,

    output logic        l2_req_out_valid_int,
    output logic        l2_rsp_out_valid_int,
    output logic        l2_rd_rsp_valid_int,
    output logic        l2_inval_valid_int,

    output l2_req_out_t l2_req_out_o,
    output l2_rsp_out_t l2_rsp_out_o,
    output line_t       l2_rd_rsp_o,
    output line_addr_t  l2_inval_o,

    output logic        req_out_stall,
    output logic        rsp_out_stall,
    output logic        rd_rsp_stall,
    output logic        inval_stall,
    output logic        out_idle
);
    l2_req_out_t req_wdata;
    l2_rsp_out_t rsp_wdata;
    logic [3:0]  empty;

    assign req_wdata.coh_msg   = req_out_coh_msg;
    assign req_wdata.hprot     = req_out_hprot;
    assign req_wdata.addr      = req_out_addr;
    assign req_wdata.line      = req_out_line;
    assign req_wdata.word_mask = req_out_word_mask;

    assign rsp_wdata.coh_msg   = rsp_out_coh_msg;
    assign rsp_wdata.req_id    = rsp_out_req_id;
    assign rsp_wdata.to_req    = rsp_out_to_req;
    assign rsp_wdata.addr      = rsp_out_addr;
    assign rsp_wdata.line      = rsp_out_line;
    assign rsp_wdata.word_mask = rsp_out_word_mask;

    l2_out_fifo #(.WIDTH($bits(l2_req_out_t)), .DEPTH(DEPTH)) u_req_out (
        .clk   (clk),
        .rst   (rst),
        .set   (set_req_out),
        .wdata (req_wdata),
        .ready (l2_req_out_ready_int),
        .valid (l2_req_out_valid_int),
        .rdata (l2_req_out_o),
        .full  (req_out_stall),
        .empty (empty[0])
    );

    l2_out_fifo #(.WIDTH($bits(l2_rsp_out_t)), .DEPTH(DEPTH)) u_rsp_out (
        .clk   (clk),
        .rst   (rst),
        .set   (set_rsp_out),
        .wdata (rsp_wdata),
        .ready (l2_rsp_out_ready_int),
        .valid (l2_rsp_out_valid_int),
        .rdata (l2_rsp_out_o),
        .full  (rsp_out_stall),
        .empty (empty[1])
    );

    l2_out_fifo #(.WIDTH($bits(line_t)), .DEPTH(DEPTH)) u_rd_rsp (
        .clk   (clk),
        .rst   (rst),
        .set   (set_rd_rsp),
        .wdata (rd_rsp_line),
        .ready (l2_rd_rsp_ready_int),
        .valid (l2_rd_rsp_valid_int),
        .rdata (l2_rd_rsp_o),
        .full  (rd_rsp_stall),
        .empty (empty[2])
    );

    l2_out_fifo #(.WIDTH($bits(line_addr_t)), .DEPTH(DEPTH)) u_inval (
        .clk   (clk),
        .rst   (rst),
        .set   (set_inval),
        .wdata (inval_addr),
        .ready (l2_inval_ready_int),
        .valid (l2_inval_valid_int),
        .rdata (l2_inval_o),
        .full  (inval_stall),
        .empty (empty[3])
    );

    assign out_idle = &empty;

endmodule
